// File: rtl/tnn_popcount_neuron.sv
// tnn_popcount_neuron
// Ternary-neuron back end: accumulates (pos_cnt - neg_cnt) over a multi-beat
// frame, closes the frame on in_last or on the beat limit, and registers a
// thresholded ternary activation behind a valid/ready output handshake.
// Optional build macro: TNN_ACC_SAT_EN selects a saturating accumulator and
// enables the sticky out_sat flag; otherwise the accumulator wraps.
module tnn_popcount_neuron #(
   parameter int ACC_W     = 10,
   parameter int MAX_BEATS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       pos_cnt,
   input  logic [4:0]       neg_cnt,
   input  logic             in_last,
   input  logic [ACC_W-1:0] thr_hi,
   input  logic [ACC_W-1:0] thr_lo,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_act,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic             out_sat
);

   localparam int              CNT_W   = 8;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
`ifdef TNN_ACC_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   // Most negative / most positive representable accumulator value.
   function automatic logic [ACC_W-1:0] sat_limit(input logic negative);
      if (negative) begin
         return {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
         return {1'b0, {(ACC_W-1){1'b1}}};
      end
   endfunction

   state_t             state_q, state_d;
   logic               in_ready_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               sat_q;
   logic               out_valid_q;
   logic [1:0]         out_act_q;
   logic [ACC_W-1:0]   out_acc_q;
   logic               out_ovf_q;
   logic               out_sat_q;

   logic               accept_s;
   logic               close_s;
   logic               hit_max_s;
   logic               ovf_close_s;
   logic [5:0]         delta_s;
   logic [ACC_W:0]     sum_s;
   logic               sum_ovf_s;
   logic               clamp_s;
   logic [ACC_W-1:0]   acc_next_s;
   logic [CNT_W-1:0]   cnt_next_s;
   logic [1:0]         act_s;

   assign accept_s    = in_valid & in_ready_q;
   assign cnt_next_s  = cnt_q + 8'd1;
   assign hit_max_s   = (cnt_next_s == MAX_CNT);
   assign close_s     = accept_s & (in_last | hit_max_s);
   assign ovf_close_s = hit_max_s & ~in_last;

   // Beat delta and one-bit-wider sum so overflow is visible as a sign mismatch.
   always_comb begin
      delta_s    = {1'b0, pos_cnt} - {1'b0, neg_cnt};
      sum_s      = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-5){delta_s[5]}}, delta_s};
      sum_ovf_s  = sum_s[ACC_W] ^ sum_s[ACC_W-1];
      clamp_s    = SAT_EN & sum_ovf_s;
      acc_next_s = sum_s[ACC_W-1:0];
      if (clamp_s) begin
         acc_next_s = sat_limit(sum_s[ACC_W]);
      end else begin
         acc_next_s = sum_s[ACC_W-1:0];
      end
   end

   // Ternary threshold compare; +1 is tested first so it wins on inverted thresholds.
   always_comb begin
      act_s = 2'b00;
      if ($signed(acc_next_s) > $signed(thr_hi)) begin
         act_s = 2'b01;
      end else if ($signed(acc_next_s) < $signed(thr_lo)) begin
         act_s = 2'b11;
      end else begin
         act_s = 2'b00;
      end
   end

   // Next-state logic: IDLE -> ACC, ACC -> OUT on closing beat, OUT -> ACC on handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_ACC;
         end
         ST_ACC: begin
            if (close_s) begin
               state_d = ST_OUT;
            end else begin
               state_d = ST_ACC;
            end
         end
         ST_OUT: begin
            if (out_valid_q && out_ready) begin
               state_d = ST_ACC;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register and registered in_ready (high exactly while in ACC).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d == ST_ACC);
      end
   end

   // Frame accumulation, result capture on the closing beat, clear on handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= {ACC_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_act_q   <= 2'b00;
         out_acc_q   <= {ACC_W{1'b0}};
         out_ovf_q   <= 1'b0;
         out_sat_q   <= 1'b0;
      end else begin
         if (close_s) begin
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            sat_q       <= 1'b0;
            out_valid_q <= 1'b1;
            out_act_q   <= act_s;
            out_acc_q   <= acc_next_s;
            out_ovf_q   <= ovf_close_s;
            out_sat_q   <= sat_q | clamp_s;
         end else if (accept_s) begin
            acc_q <= acc_next_s;
            cnt_q <= cnt_next_s;
            sat_q <= sat_q | clamp_s;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_act   = out_act_q;
   assign out_acc   = out_acc_q;
   assign out_ovf   = out_ovf_q;
   assign out_sat   = out_sat_q;

endmodule
